// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM states,
// BCD time layout, seven-segment glyphs and the BCD increment helper.
package stopwatch_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 500000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
        logic [3:0] cs_t;
        logic [3:0] cs_u;
    } bcd_time_t;

    localparam bcd_time_t BCD_MAX = bcd_time_t'(24'h595999);

    // Active-low segments, bit0 = a .. bit6 = g.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // One centisecond step with carries rippling through all six digits.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.cs_u != 4'd9) begin
            r.cs_u = t.cs_u + 4'd1;
        end else begin
            r.cs_u = 4'd0;
            if (t.cs_t != 4'd9) begin
                r.cs_t = t.cs_t + 4'd1;
            end else begin
                r.cs_t = 4'd0;
                if (t.sec_u != 4'd9) begin
                    r.sec_u = t.sec_u + 4'd1;
                end else begin
                    r.sec_u = 4'd0;
                    if (t.sec_t != 4'd5) begin
                        r.sec_t = t.sec_t + 4'd1;
                    end else begin
                        r.sec_t = 4'd0;
                        if (t.min_u != 4'd9) begin
                            r.min_u = t.min_u + 4'd1;
                        end else begin
                            r.min_u = 4'd0;
                            if (t.min_t != 4'd5) begin
                                r.min_t = t.min_t + 4'd1;
                            end else begin
                                r.min_t = 4'd0;
                            end
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear stopwatch: key conditioning, run/pause FSM, 10 ms
// prescaler and MM:SS.CC BCD counter driving six seven-segment displays.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_IDLE  | cleared, prescaler and count held at zero
//   ST_RUN   | prescaler running, count advances each tick
//   ST_PAUSE | prescaler and count frozen, display holds
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] KEY,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LED
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [1:0] key_s1_q;
    logic [1:0] key_s2_q;
    logic [1:0] key_prev_q;
    logic [1:0] settle_q;
    logic [1:0] press;
    logic       start_p;
    logic       clear_p;

    sw_state_e  state_q;
    sw_state_e  state_d;
    logic       run_q;
    logic       run_d;
    logic       pause_q;
    logic       pause_d;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;
    bcd_time_t     cnt_q;
    bcd_time_t     cnt_d;
    logic          ovf_q;
    logic          ovf_d;

    // The settle window hides the edge detector for the first three cycles
    // after reset, so a key already held low through reset is never seen as
    // a fresh press; it must be released and pressed again.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_s1_q   <= 2'b11;
            key_s2_q   <= 2'b11;
            key_prev_q <= 2'b11;
            settle_q   <= 2'd3;
        end else begin
            key_s1_q   <= KEY;
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
            if (settle_q != 2'd0) begin
                settle_q <= settle_q - 2'd1;
            end
        end
    end

    assign press   = key_prev_q & ~key_s2_q & {2{settle_q == 2'd0}};
    assign start_p = press[0];
    assign clear_p = press[1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_p) begin
            state_d = ST_IDLE;
        end else if (start_p) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        run_d   = (state_d == ST_RUN);
        pause_d = (state_d == ST_PAUSE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            run_q   <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            pause_q <= pause_d;
        end
    end

    // A tick on the same edge as a state change is applied first; leaving
    // for IDLE then overrides everything back to zero.
    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_RUN:   presc_d = tick ? '0 : presc_q + PW'(1);
            ST_PAUSE: presc_d = presc_q;
            default:  presc_d = '0;
        endcase
        if (tick) begin
            cnt_d = bcd_inc(cnt_q);
            if (cnt_q == BCD_MAX) begin
                ovf_d = 1'b1;
            end
        end
        if (state_d == ST_IDLE) begin
            presc_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    seg7_decoder u_hex0 (.digit_i(cnt_q.cs_u),  .seg_o(HEX0));
    seg7_decoder u_hex1 (.digit_i(cnt_q.cs_t),  .seg_o(HEX1));
    seg7_decoder u_hex2 (.digit_i(cnt_q.sec_u), .seg_o(HEX2));
    seg7_decoder u_hex3 (.digit_i(cnt_q.sec_t), .seg_o(HEX3));
    seg7_decoder u_hex4 (.digit_i(cnt_q.min_u), .seg_o(HEX4));
    seg7_decoder u_hex5 (.digit_i(cnt_q.min_t), .seg_o(HEX5));

    assign LED = {ovf_q, 7'b0000000, pause_q, run_q};

endmodule
